// File: rtl/div3_seq_arbiter.sv
// Bit-serial divide-by-3 engine shared by two requesters through a
// round-robin arbiter. One operand is divided MSB first, one bit per cycle,
// and the result is held on a valid/ready response port.
module div3_seq_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_x,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_x,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_q,
  output logic [1:0]       rsp_r,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [1:0]       rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             grant0, grant1;
  logic [2:0]       t;
  logic             qbit;
  logic [1:0]       rem_nxt;

  // Arbitration: favoured requester wins, otherwise the other one if valid.
  always_comb begin
    grant0 = (state_q == IDLE) && req0_valid && (!prio_q || !req1_valid);
    grant1 = (state_q == IDLE) && req1_valid && ( prio_q || !req0_valid);
  end

  // One step of the remainder recurrence: t = 2*rem + msb.
  always_comb begin
    t       = {rem_q, sh_q[WIDTH-1]};
    qbit    = (t >= 3'd3);
    rem_nxt = qbit ? 2'(t - 3'd3) : t[1:0];
  end

  // Next-state logic for the sequencer and datapath registers.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    sh_d    = sh_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          sh_d    = grant1 ? req1_x : req0_x;
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          id_d    = grant1;
          prio_d  = !grant1;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem_nxt;
        quo_d = {quo_q[WIDTH-2:0], qbit};
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      sh_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      sh_q    <= sh_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response fields come straight from registers and only change on accept/RUN.
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp_valid  = (state_q == DONE);
    busy       = (state_q != IDLE);
    rsp_id     = id_q;
    rsp_q      = quo_q;
    rsp_r      = rem_q;
  end

endmodule
